normalize_mantisa: RTL and testbench
====================================

// Module: normalize_mantisa
// PURPOSE
//  Post-add normalizer for the dual-mode FP adder. It is the back end of the align_mantisa datapath.
//  Takes the 54-bit aligned sum and the large exponent, and produces a normalized 53-bit fraction and exponent.
//  i_mode=1: one double lane. i_mode=0: two packed single lanes.
//  Handling per lane:
//   - carry-out: right-shift by 1, exponent +1.
//   - leading zeros: left-shift by the LZ count, exponent minus the count.
//   - zero sum, exponent overflow and exponent underflow are flagged.
//  Two-stage pipeline with valid/ready: stage 1 = carry detect and LZC, stage 2 = shift and exponent adjust.
// PARAMETERS
//  FRAC_W      54    sum input width (carry bit + 53-bit fraction)
//  EXP_W       16    exponent field width (double: [10:0]; singles: [7:0] lane0, [15:8] lane1)
//  DBL_EXP_MAX 2047  double overflow exponent
//  SGL_EXP_MAX 255   single overflow exponent
// PORTS
//  i_clk        in   1   clock
//  i_rst        in   1   synchronous reset, active-high
//  i_valid      in   1   input transaction valid
//  o_ready      out  1   block can accept the input this cycle
//  i_mode       in   1   1 = double, 0 = two singles; captured with the transaction
//  a_sum_frac54 in   54  sum in align_mantisa layout
//  a_exp16      in   16  large exponent(s) in align_mantisa layout
//  n_valid      out  1   result valid
//  i_ready      in   1   downstream accepts the result
//  n_frac53     out  53  normalized fraction (hidden bit included)
//  n_exp16      out  16  adjusted exponent(s)
//  n_zero       out  2   per-lane zero sum
//  n_ovf        out  2   per-lane exponent overflow
//  n_unf        out  2   per-lane exponent underflow
// BEHAVIOUR
//  Reset: both stage valids 0; n_valid=0; n_frac53, n_exp16, n_zero, n_ovf, n_unf all 0.
//   Reset applied mid-operation drops in-flight transactions; o_ready=1 on the first cycle after reset.
//  Handshake:
//   - en2 = ~v2 | i_ready; en1 = ~v1 | en2; o_ready = en1.
//   - Transfer occurs when valid & ready. Throughput 1 per cycle; latency 2 cycles from accept to n_valid.
//   - Outputs stay stable while n_valid & ~i_ready. Order is preserved; no drop, no duplicate.
//   - Accept and retire in the same cycle is legal while the pipe is full.
//  Lane fields:
//   - Double: F = sum[53:0] (carry at bit 53), E = exp[10:0]. exp[15:11] ignored; n_exp16[15:11] = 0.
//   - Single lane0: F = sum[24:0] (carry at bit 24), E = exp[7:0].
//   - Single lane1: F = sum[53:29] (carry at bit 53), E = exp[15:8].
//   - Single output packing: lane0 frac in n_frac53[23:0], lane1 in [52:29], [28:24] = 0.
//  Per-lane rules (W = field width without carry, MAX = lane max exponent):
//   - Carry set: frac = F >> 1, exp = E+1. If E+1 >= MAX: ovf=1, exp=MAX, frac=0.
//   - F == 0: zero=1, exp=0, frac=0.
//   - Otherwise: lz = leading zeros of F[W-1:0]. If E > lz: frac = F << lz, exp = E - lz.
//     Else underflow; see CONFIGURATION.
//   - Carry set and zero are mutually exclusive. Flags are exclusive per lane.
//  Flag bit 1 and lane1 exponent are 0 in double mode.
// CONFIGURATION
//  NORM_SUBNORMAL_EN defined:
//   - On underflow (E <= lz): frac = F << (E-1), or F unshifted when E = 0; exp = 0; unf = 1.
//  NORM_SUBNORMAL_EN undefined:
//   - On underflow: flush to zero, i.e. frac = 0, exp = 0, unf = 1.
// TESTING
//  Double carry:
//   mode=1, sum=54'h20_0000_0000_0000, exp=16'h03FF
//   -> frac=53'h10_0000_0000_0000, exp=16'h0400, flags 0, n_valid 2 cycles after accept.
//  Double leading zeros:
//   mode=1, sum=2^50, exp=16'h03FF -> frac=2^52, exp=16'h03FD.
//   Same sum with exp=16'h07FE and carry bit set -> ovf[0]=1, exp=16'h07FF, frac=0.
//  Packed singles:
//   mode=0, sum=2^50|2^24, exp=16'h7F7F
//   -> frac=53'h10_0000_0080_0000, exp=16'h7D80, flags 0.
//   mode=0, sum=0 -> n_zero=2'b11, exp=0.
//  Underflow:
//   mode=1, sum=2^40, exp=16'h0005 -> unf[0]=1.
//   Without the macro: frac=0, exp=0. With NORM_SUBNORMAL_EN: frac=2^44, exp=0.
//  Backpressure:
//   - Issue 4 back-to-back inputs with i_ready=0 for 3 cycles.
//   - o_ready drops once 2 are held; n_frac53 stays stable.
//   - All 4 results emerge in order, none lost or duplicated.
//  Reset mid-operation:
//   - Assert i_rst with 2 transactions in flight.
//   - Next cycle: n_valid=0, outputs 0, o_ready=1.
//   - The next accepted input appears 2 cycles later with no stale data.

Source files
------------

// File: rtl/normalize_mantisa.sv
// rtl/normalize_mantisa.sv - two-stage post-add normalizer for the dual-mode FP adder
//
// Purpose: takes the aligned 54-bit sum and the large exponent(s) produced by the
// align_mantisa datapath and returns a normalized fraction and adjusted exponent.
// One double lane (i_mode=1) or two packed single lanes (i_mode=0).
// Stage 1 registers carry/zero detection and leading-zero counts, stage 2 shifts,
// adjusts exponents and raises per-lane zero/overflow/underflow flags.
//
// Build option: NORM_SUBNORMAL_EN - when defined, underflowing lanes produce a
// denormal fraction instead of being flushed to zero.
//
// Ports:
//   i_clk, i_rst           clock, synchronous active-high reset
//   i_valid, o_ready       input handshake
//   i_mode                 1 = double, 0 = two singles
//   a_sum_frac54, a_exp16  aligned sum and large exponent(s)
//   n_valid, i_ready       output handshake
//   n_frac53, n_exp16      normalized fraction (hidden bit included) and exponent(s)
//   n_zero, n_ovf, n_unf   per-lane flags (bit 0 = lane0 / double, bit 1 = lane1)

module normalize_mantisa #(
    parameter int FRAC_W      = 54,
    parameter int EXP_W       = 16,
    parameter int DBL_EXP_MAX = 2047,
    parameter int SGL_EXP_MAX = 255
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic              i_mode,
    input  logic [FRAC_W-1:0] a_sum_frac54,
    input  logic [EXP_W-1:0]  a_exp16,
    output logic              n_valid,
    input  logic              i_ready,
    output logic [FRAC_W-2:0] n_frac53,
    output logic [EXP_W-1:0]  n_exp16,
    output logic [1:0]        n_zero,
    output logic [1:0]        n_ovf,
    output logic [1:0]        n_unf
);

    localparam logic [10:0] DBL_MAX = DBL_EXP_MAX[10:0];
    localparam logic [7:0]  SGL_MAX = SGL_EXP_MAX[7:0];

    typedef struct packed {
        logic [23:0] frac;
        logic [7:0]  exp;
        logic        zero;
        logic        ovf;
        logic        unf;
    } sgl_res_t;

    // Leading-zero counts; an all-zero field returns the full width.
    function automatic logic [5:0] lzc53(input logic [52:0] v);
        logic [5:0] n;
        n = 6'd53;
        for (int i = 0; i < 53; i++) begin
            if (v[i]) n = 6'(52 - i);
        end
        return n;
    endfunction

    function automatic logic [4:0] lzc24(input logic [23:0] v);
        logic [4:0] n;
        n = 5'd24;
        for (int i = 0; i < 24; i++) begin
            if (v[i]) n = 5'(23 - i);
        end
        return n;
    endfunction

    function automatic sgl_res_t norm_single(input logic [24:0] f, input logic [7:0] e,
                                             input logic [4:0] lz, input logic zero);
        sgl_res_t   r;
        logic [8:0] e1;
        r  = '0;
        e1 = {1'b0, e} + 9'd1;
        if (zero) begin
            r.zero = 1'b1;
        end else if (f[24]) begin
            if (e1 >= {1'b0, SGL_MAX}) begin
                r.ovf = 1'b1;
                r.exp = SGL_MAX;
            end else begin
                r.frac = f[24:1];
                r.exp  = e1[7:0];
            end
        end else if (e > {3'd0, lz}) begin
            r.frac = f[23:0] << lz;
            r.exp  = e - {3'd0, lz};
        end else begin
            r.unf = 1'b1;
`ifdef NORM_SUBNORMAL_EN
            r.frac = (e == 8'd0) ? f[23:0] : (f[23:0] << (e - 8'd1));
`endif
        end
        return r;
    endfunction

    // Handshake: each stage advances when it is empty or the stage after it drains.
    logic v1;
    logic en1, en2;

    assign en2     = ~n_valid | i_ready;
    assign en1     = ~v1 | en2;
    assign o_ready = en1;

    // Stage 1: capture and detect
    logic        mode1;
    logic [53:0] sum1;
    logic [15:0] exp1;
    logic [5:0]  lz_d1;
    logic [4:0]  lz_a1, lz_b1;
    logic        zero_d1, zero_a1, zero_b1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            v1 <= 1'b0;
        end else if (en1) begin
            v1 <= i_valid;
            if (i_valid) begin
                mode1   <= i_mode;
                sum1    <= a_sum_frac54;
                exp1    <= a_exp16;
                lz_d1   <= lzc53(a_sum_frac54[52:0]);
                lz_a1   <= lzc24(a_sum_frac54[23:0]);
                lz_b1   <= lzc24(a_sum_frac54[52:29]);
                zero_d1 <= (a_sum_frac54 == 54'd0);
                zero_a1 <= (a_sum_frac54[24:0] == 25'd0);
                zero_b1 <= (a_sum_frac54[53:29] == 25'd0);
            end
        end
    end

    // Stage 2 combinational: shift and exponent adjust
    logic [52:0] d_frac;
    logic [10:0] d_exp;
    logic [11:0] d_e1;
    logic        d_zero, d_ovf, d_unf;
    sgl_res_t    r_a, r_b;
    logic [52:0] nxt_frac;
    logic [15:0] nxt_exp;
    logic [1:0]  nxt_zero, nxt_ovf, nxt_unf;

    always_comb begin
        d_frac = '0;
        d_exp  = '0;
        d_zero = 1'b0;
        d_ovf  = 1'b0;
        d_unf  = 1'b0;
        d_e1   = {1'b0, exp1[10:0]} + 12'd1;
        if (zero_d1) begin
            d_zero = 1'b1;
        end else if (sum1[53]) begin
            if (d_e1 >= {1'b0, DBL_MAX}) begin
                d_ovf = 1'b1;
                d_exp = DBL_MAX;
            end else begin
                d_frac = sum1[53:1];
                d_exp  = d_e1[10:0];
            end
        end else if (exp1[10:0] > {5'd0, lz_d1}) begin
            d_frac = sum1[52:0] << lz_d1;
            d_exp  = exp1[10:0] - {5'd0, lz_d1};
        end else begin
            d_unf = 1'b1;
`ifdef NORM_SUBNORMAL_EN
            d_frac = (exp1[10:0] == 11'd0) ? sum1[52:0] : (sum1[52:0] << (exp1[10:0] - 11'd1));
`endif
        end

        r_a = norm_single(sum1[24:0], exp1[7:0], lz_a1, zero_a1);
        r_b = norm_single(sum1[53:29], exp1[15:8], lz_b1, zero_b1);

        if (mode1) begin
            nxt_frac = d_frac;
            nxt_exp  = {5'd0, d_exp};
            nxt_zero = {1'b0, d_zero};
            nxt_ovf  = {1'b0, d_ovf};
            nxt_unf  = {1'b0, d_unf};
        end else begin
            nxt_frac = {r_b.frac, 5'd0, r_a.frac};
            nxt_exp  = {r_b.exp, r_a.exp};
            nxt_zero = {r_b.zero, r_a.zero};
            nxt_ovf  = {r_b.ovf, r_a.ovf};
            nxt_unf  = {r_b.unf, r_a.unf};
        end
    end

    // Stage 2 registers drive the outputs directly and hold under backpressure.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            n_valid  <= 1'b0;
            n_frac53 <= '0;
            n_exp16  <= '0;
            n_zero   <= '0;
            n_ovf    <= '0;
            n_unf    <= '0;
        end else if (en2) begin
            n_valid <= v1;
            if (v1) begin
                n_frac53 <= nxt_frac;
                n_exp16  <= nxt_exp;
                n_zero   <= nxt_zero;
                n_ovf    <= nxt_ovf;
                n_unf    <= nxt_unf;
            end
        end
    end

endmodule

// File: tb/tb_normalize_mantisa.sv
// tb/tb_normalize_mantisa.sv - self-checking bench for normalize_mantisa

module tb_normalize_mantisa;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic        i_mode = 1'b1;
    logic [53:0] a_sum_frac54 = '0;
    logic [15:0] a_exp16 = '0;
    logic        n_valid;
    logic        i_ready = 1'b1;
    logic [52:0] n_frac53;
    logic [15:0] n_exp16;
    logic [1:0]  n_zero, n_ovf, n_unf;

    int total = 0;
    int bad = 0;
    int lat;

    always #5 i_clk = ~i_clk;

    normalize_mantisa dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_mode       (i_mode),
        .a_sum_frac54 (a_sum_frac54),
        .a_exp16      (a_exp16),
        .n_valid      (n_valid),
        .i_ready      (i_ready),
        .n_frac53     (n_frac53),
        .n_exp16      (n_exp16),
        .n_zero       (n_zero),
        .n_ovf        (n_ovf),
        .n_unf        (n_unf)
    );

    // Drive one transaction and wait (bounded) for its result; lat counts cycles.
    task automatic run_one(input logic m, input logic [53:0] s, input logic [15:0] e);
        @(negedge i_clk);
        i_mode = m; a_sum_frac54 = s; a_exp16 = e; i_valid = 1'b1; i_ready = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_valid = 1'b0;
        lat = 1;
        while (!n_valid && lat < 10) begin
            @(negedge i_clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL reset o_ready: got %b want 1", o_ready); end
        total++; if (n_valid !== 1'b0) begin bad++; $display("FAIL reset n_valid: got %b want 0", n_valid); end
        total++; if (n_frac53 !== 53'd0 || n_exp16 !== 16'd0) begin
            bad++; $display("FAIL reset data: got frac=%h exp=%h want 0", n_frac53, n_exp16); end
        total++; if ({n_zero, n_ovf, n_unf} !== 6'd0) begin
            bad++; $display("FAIL reset flags: got %b want 000000", {n_zero, n_ovf, n_unf}); end
    endtask

    task automatic test_double_carry;
        run_one(1'b1, 54'h20_0000_0000_0000, 16'h03FF);
        total++; if (lat !== 2) begin bad++; $display("FAIL dbl_carry latency: got %0d want 2", lat); end
        total++; if (n_frac53 !== 53'h10_0000_0000_0000) begin
            bad++; $display("FAIL dbl_carry frac: got %h want 10000000000000", n_frac53); end
        total++; if (n_exp16 !== 16'h0400) begin bad++; $display("FAIL dbl_carry exp: got %h want 0400", n_exp16); end
        total++; if ({n_zero, n_ovf, n_unf} !== 6'd0) begin
            bad++; $display("FAIL dbl_carry flags: got %b want 000000", {n_zero, n_ovf, n_unf}); end
    endtask

    task automatic test_double_lz;
        run_one(1'b1, 54'h04_0000_0000_0000, 16'h03FF);
        total++; if (n_frac53 !== 53'h10_0000_0000_0000 || n_exp16 !== 16'h03FD) begin
            bad++; $display("FAIL dbl_lz: got frac=%h exp=%h want 10000000000000/03FD", n_frac53, n_exp16); end
        total++; if ({n_zero, n_ovf, n_unf} !== 6'd0) begin
            bad++; $display("FAIL dbl_lz flags: got %b want 000000", {n_zero, n_ovf, n_unf}); end
        // upper exponent bits are ignored in double mode
        run_one(1'b1, 54'h04_0000_0000_0000, 16'hFBFF);
        total++; if (n_exp16 !== 16'h03FD) begin bad++; $display("FAIL dbl_hi_exp: got %h want 03FD", n_exp16); end
        run_one(1'b1, 54'h24_0000_0000_0000, 16'h07FE);
        total++; if (n_ovf !== 2'b01 || n_exp16 !== 16'h07FF || n_frac53 !== 53'd0) begin
            bad++; $display("FAIL dbl_ovf: got ovf=%b exp=%h frac=%h want 01/07FF/0", n_ovf, n_exp16, n_frac53); end
        total++; if (n_zero !== 2'b00 || n_unf !== 2'b00) begin
            bad++; $display("FAIL dbl_ovf excl: got zero=%b unf=%b want 00/00", n_zero, n_unf); end
    endtask

    task automatic test_singles;
        run_one(1'b0, 54'h04_0000_0100_0000, 16'h7F7F);
        total++; if (n_frac53 !== 53'h10_0000_0080_0000) begin
            bad++; $display("FAIL sgl_pack frac: got %h want 10000000800000", n_frac53); end
        total++; if (n_exp16 !== 16'h7D80) begin bad++; $display("FAIL sgl_pack exp: got %h want 7D80", n_exp16); end
        total++; if ({n_zero, n_ovf, n_unf} !== 6'd0) begin
            bad++; $display("FAIL sgl_pack flags: got %b want 000000", {n_zero, n_ovf, n_unf}); end
        run_one(1'b0, 54'd0, 16'h7F7F);
        total++; if (n_zero !== 2'b11 || n_exp16 !== 16'h0000 || n_frac53 !== 53'd0) begin
            bad++; $display("FAIL sgl_zero: got zero=%b exp=%h frac=%h want 11/0000/0", n_zero, n_exp16, n_frac53); end
        run_one(1'b0, 54'h10_0000_0100_0000, 16'h10FE);
        total++; if (n_ovf !== 2'b01 || n_exp16 !== 16'h10FF || n_frac53 !== 53'h10_0000_0000_0000) begin
            bad++; $display("FAIL sgl_ovf: got ovf=%b exp=%h frac=%h want 01/10FF/10000000000000", n_ovf, n_exp16, n_frac53); end
    endtask

    task automatic test_underflow;
        logic [52:0] want_f;
`ifdef NORM_SUBNORMAL_EN
        want_f = 53'h1000_0000_0000;
`else
        want_f = 53'd0;
`endif
        run_one(1'b1, 54'h100_0000_0000, 16'h0005);
        total++; if (n_unf !== 2'b01 || n_zero !== 2'b00 || n_ovf !== 2'b00) begin
            bad++; $display("FAIL dbl_unf flags: got unf=%b zero=%b ovf=%b want 01/00/00", n_unf, n_zero, n_ovf); end
        total++; if (n_frac53 !== want_f || n_exp16 !== 16'h0000) begin
            bad++; $display("FAIL dbl_unf data: got frac=%h exp=%h want %h/0000", n_frac53, n_exp16, want_f); end
    endtask

    task automatic test_backpressure;
        logic [52:0] want_f[4];
        logic [15:0] want_e[4];
        logic [52:0] held;
        logic        hold_prev;
        int          sent, got, extra;
        for (int k = 0; k < 4; k++) begin
            want_f[k] = 53'h10_0000_0000_0000 + 53'(k);
            want_e[k] = 16'h0200 + 16'(k);
        end
        sent = 0; got = 0; hold_prev = 1'b0; held = '0;
        for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
            @(negedge i_clk);
            if (hold_prev) begin
                total++; if (n_frac53 !== held) begin
                    bad++; $display("FAIL bp_stable cyc%0d: got %h want %h", cyc, n_frac53, held); end
            end
            i_ready = (cyc >= 3);
            if (sent < 4) begin
                i_valid = 1'b1; i_mode = 1'b1;
                a_sum_frac54 = {1'b0, want_f[sent]}; a_exp16 = want_e[sent];
            end else begin
                i_valid = 1'b0;
            end
            #1;
            if (cyc == 2) begin
                total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL bp_o_ready: got %b want 0", o_ready); end
            end
            if (i_valid && o_ready) sent++;
            if (n_valid && i_ready) begin
                total++; if (n_frac53 !== want_f[got] || n_exp16 !== want_e[got]) begin
                    bad++; $display("FAIL bp_order #%0d: got %h/%h want %h/%h", got, n_frac53, n_exp16, want_f[got], want_e[got]); end
                got++;
            end
            hold_prev = n_valid && !i_ready;
            held = n_frac53;
        end
        i_valid = 1'b0; i_ready = 1'b1;
        total++; if (got !== 4 || sent !== 4) begin
            bad++; $display("FAIL bp_count: got sent=%0d retired=%0d want 4/4", sent, got); end
        extra = 0;
        repeat (3) begin @(negedge i_clk); if (n_valid) extra++; end
        total++; if (extra !== 0) begin bad++; $display("FAIL bp_dup: got %0d extra results want 0", extra); end
    endtask

    task automatic test_reset_mid;
        int extra;
        @(negedge i_clk);
        i_ready = 1'b0; i_valid = 1'b1; i_mode = 1'b1;
        a_sum_frac54 = 54'h20_0000_0000_0000; a_exp16 = 16'h0100;
        @(negedge i_clk);
        a_sum_frac54 = 54'h04_0000_0000_0000;
        @(negedge i_clk);
        i_valid = 1'b0;
        total++; if (n_valid !== 1'b1 || o_ready !== 1'b0) begin
            bad++; $display("FAIL rst_mid fill: got n_valid=%b o_ready=%b want 1/0", n_valid, o_ready); end
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        total++; if (n_valid !== 1'b0 || o_ready !== 1'b1) begin
            bad++; $display("FAIL rst_mid hs: got n_valid=%b o_ready=%b want 0/1", n_valid, o_ready); end
        total++; if (n_frac53 !== 53'd0 || n_exp16 !== 16'd0 || {n_zero, n_ovf, n_unf} !== 6'd0) begin
            bad++; $display("FAIL rst_mid data: got frac=%h exp=%h flags=%b want 0", n_frac53, n_exp16, {n_zero, n_ovf, n_unf}); end
        run_one(1'b1, 54'h10_0000_0000_0003, 16'h0123);
        total++; if (lat !== 2 || n_frac53 !== 53'h10_0000_0000_0003 || n_exp16 !== 16'h0123) begin
            bad++; $display("FAIL rst_mid next: got lat=%0d frac=%h exp=%h want 2/10000000000003/0123", lat, n_frac53, n_exp16); end
        extra = 0;
        repeat (3) begin @(negedge i_clk); if (n_valid) extra++; end
        total++; if (extra !== 0) begin bad++; $display("FAIL rst_mid stale: got %0d extra results want 0", extra); end
    endtask

    initial begin
        test_reset;
        test_double_carry;
        test_double_lz;
        test_singles;
        test_underflow;
        test_backpressure;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
